// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter; the frame format (5..9 data bits, parity none/odd/even, 1-2 stop bits) is fixed at elaboration.
// Define UART_TX_FIFO_EN to place a p_FIFO_DEPTH-entry write FIFO in front of the serialiser.
module uart_tx_cfg #(
    parameter int p_CLK_FREQ   = 12_000_000,
    parameter int p_BAUDRATE   = 9600,
    parameter int p_DATA_BITS  = 8,
    parameter int p_PARITY     = 0,
    parameter int p_STOP_BITS  = 1,
    parameter int p_FIFO_DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [p_DATA_BITS-1:0] i_txdata,
    output logic                   o_ready,
    output logic                   o_done,
    output logic                   o_busy,
    output logic                   o_uart_tx
);
    localparam int c_DIV   = (p_CLK_FREQ + p_BAUDRATE / 2) / p_BAUDRATE;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_DIV - 1);
    localparam logic [3:0]         c_DATA_LAST = 4'(p_DATA_BITS - 1);
    localparam logic [3:0]         c_STOP_LAST = 4'(p_STOP_BITS - 1);

    if (p_DATA_BITS < 5 || p_DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: p_DATA_BITS must be 5..9");
    end
    if (p_PARITY < 0 || p_PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: p_PARITY must be 0, 1 or 2");
    end
    if (p_STOP_BITS < 1 || p_STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: p_STOP_BITS must be 1 or 2");
    end
    if (c_DIV < 1) begin : g_bad_divider
        $error("uart_tx_cfg: p_BAUDRATE too high for p_CLK_FREQ");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state;
    logic [c_CNT_W-1:0]     cnt;
    logic [3:0]             bit_idx;
    logic [p_DATA_BITS-1:0] shreg;
    logic                   par_bit;
    logic                   load;
    logic [p_DATA_BITS-1:0] load_data;
    logic                   bit_end;

    assign bit_end = (cnt == c_CNT_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int c_AW = (p_FIFO_DEPTH > 1) ? $clog2(p_FIFO_DEPTH) : 1;

    if (p_FIFO_DEPTH < 2 || (p_FIFO_DEPTH & (p_FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_cfg: p_FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic [p_DATA_BITS-1:0] mem [p_FIFO_DEPTH];
    logic [c_AW:0]          wr_ptr;
    logic [c_AW:0]          rd_ptr;
    logic                   empty;
    logic                   full;
    logic                   push;

    // The extra pointer bit separates a full FIFO from an empty one when the addresses match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[c_AW] != rd_ptr[c_AW]) && (wr_ptr[c_AW-1:0] == rd_ptr[c_AW-1:0]);
    assign push      = i_en && !full;
    assign load      = (state == S_IDLE) && !empty;
    assign load_data = mem[rd_ptr[c_AW-1:0]];
    assign o_ready   = !full;
    assign o_busy    = (state != S_IDLE) || !empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[c_AW-1:0]] <= i_txdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    logic unused_fifo_depth;

    assign unused_fifo_depth = (p_FIFO_DEPTH != 0);
    assign load              = (state == S_IDLE) && i_en;
    assign load_data         = i_txdata;
    assign o_ready           = (state == S_IDLE);
    assign o_busy            = (state != S_IDLE);
`endif

    // Each line bit lasts c_DIV cycles; the line value is registered on the boundary into the bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            o_uart_tx <= 1'b1;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (load) begin
                        shreg     <= load_data;
                        par_bit   <= (p_PARITY == 1) ? ~(^load_data) : (^load_data);
                        o_uart_tx <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        o_uart_tx <= shreg[0];
                        shreg     <= shreg >> 1;
                        state     <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == c_DATA_LAST) begin
                            bit_idx <= '0;
                            if (p_PARITY != 0) begin
                                o_uart_tx <= par_bit;
                                state     <= S_PARITY;
                            end else begin
                                o_uart_tx <= 1'b1;
                                state     <= S_STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            o_uart_tx <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        o_uart_tx <= 1'b1;
                        state     <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == c_STOP_LAST) begin
                            bit_idx <= '0;
                            o_done  <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    o_uart_tx <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: random frames on several frame formats, each compared bit-centre by bit-centre with a queue-built frame.
// Also covers mid-frame reset, back-to-back writes and, with UART_TX_FIFO_EN, a FIFO fill burst.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    localparam int NCFG = 5;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    function automatic int cfgClk(input int g);
        return (g == 0) ? 12_000_000 : ((g == 4) ? 75 : 100);
    endfunction
    function automatic int cfgBaud(input int g);
        return (g == 0) ? 9600 : 10;
    endfunction
    function automatic int cfgBits(input int g);
        return (g == 3) ? 7 : ((g == 4) ? 9 : 8);
    endfunction
    function automatic int cfgPar(input int g);
        return (g == 1 || g == 4) ? 2 : ((g == 2) ? 1 : 0);
    endfunction
    function automatic int cfgStop(input int g);
        return (g == 3) ? 2 : 1;
    endfunction
    function automatic int cfgDepth(input int g);
        return (g == 0) ? 2 : 4;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Returns 1 time unit after the rising edge that starts cycle c.
    task automatic waitCyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : gCfg
        localparam int CLKF  = cfgClk(g);
        localparam int BAUD  = cfgBaud(g);
        localparam int NB    = cfgBits(g);
        localparam int PAR   = cfgPar(g);
        localparam int STOP  = cfgStop(g);
        localparam int DEPTH = cfgDepth(g);
        localparam int DIV   = (CLKF + BAUD / 2) / BAUD;
        localparam int NF    = (DIV > 100) ? (3 - LAT) : 10;

        logic          rst;
        logic          en;
        logic [NB-1:0] txdata;
        logic          ready;
        logic          done;
        logic          busy;
        logic          tx;
        bit            fin = 1'b0;

        uart_tx_cfg #(
            .p_CLK_FREQ  (CLKF),
            .p_BAUDRATE  (BAUD),
            .p_DATA_BITS (NB),
            .p_PARITY    (PAR),
            .p_STOP_BITS (STOP),
            .p_FIFO_DEPTH(DEPTH)
        ) dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_en     (en),
            .i_txdata (txdata),
            .o_ready  (ready),
            .o_done   (done),
            .o_busy   (busy),
            .o_uart_tx(tx)
        );

        function automatic string tag(input string s);
            return $sformatf("c%0d.%s", g, s);
        endfunction

        // Frame whose start bit begins in cycle s; returns during its o_done cycle.
        task automatic checkFrame(input int s, input logic [8:0] d, input bit expReadyMid, input bit expBusyDone);
            bit q[$];
            int ones = 0;
            q.push_back(1'b0);
            for (int i = 0; i < NB; i++) begin
                q.push_back(d[i]);
                ones += int'(d[i]);
            end
            if (PAR == 1) q.push_back(ones % 2 == 0);
            if (PAR == 2) q.push_back(ones % 2 == 1);
            for (int i = 0; i < STOP; i++) q.push_back(1'b1);
            for (int k = 0; k < q.size(); k++) begin
                waitCyc(s + k * DIV + DIV / 2);
                checkOutput(tag($sformatf("bit%0d", k)), 32'(tx), 32'(q[k]));
                if (k == 0) begin
                    checkOutput(tag("busyMid"), 32'(busy), 1);
                    checkOutput(tag("readyMid"), 32'(ready), 32'(expReadyMid));
                end
            end
            waitCyc(s + q.size() * DIV - 1);
            checkOutput(tag("doneEarly"), 32'(done), 0);
            waitCyc(s + q.size() * DIV);
            checkOutput(tag("done"), 32'(done), 1);
            checkOutput(tag("lineIdleAtDone"), 32'(tx), 1);
            checkOutput(tag("busyAtDone"), 32'(busy), 32'(expBusyDone));
        endtask

        task automatic applyStimulus();
            int         c;
            int         occ;
            int         popCyc;
            bit         idle;
            bit         hold;
            bit         sawDone;
            bit         sawLow;
            logic [8:0] d;
            logic [8:0] nd;
            logic [8:0] w;
            logic [8:0] fq[$];

            rst = 1'b1;
            en = 1'b0;
            txdata = '0;
            waitCyc(3);
            checkOutput(tag("rstTx"), 32'(tx), 1);
            checkOutput(tag("rstReady"), 32'(ready), 1);
            checkOutput(tag("rstDone"), 32'(done), 0);
            checkOutput(tag("rstBusy"), 32'(busy), 0);
            rst = 1'b0;

            d = 9'h021;
            waitCyc(cyc + 2);
            @(negedge clk);
            c = cyc;
            en = 1'b1;
            txdata = d[NB-1:0];
            for (int f = 0; f < NF; f++) begin
                hold = (LAT == 1) && (f < NF - 1) && (f == 0 || $urandom_range(0, 1) == 1);
                nd = (f == 0) ? 9'h022 : 9'($urandom);
                w = 9'($urandom);
                waitCyc(c + 1);
                en = hold;
                txdata = w[NB-1:0];
                checkFrame(c + LAT, d, 1'(LAT == 2), 1'b0);
                checkOutput(tag("readyAtDone"), 32'(ready), 1);
                if (hold) begin
                    txdata = nd[NB-1:0];
                    c = cyc;
                end else begin
                    en = 1'b0;
                    if (f < NF - 1) begin
                        waitCyc(cyc + int'($urandom_range(1, 6)));
                        @(negedge clk);
                        c = cyc;
                        en = 1'b1;
                        txdata = nd[NB-1:0];
                    end
                end
                d = nd;
            end

            // Mid-frame reset during the third data bit of 'h21, which is a 0 on the line.
            waitCyc(cyc + 3);
            @(negedge clk);
            c = cyc;
            en = 1'b1;
            d = 9'h021;
            txdata = d[NB-1:0];
            waitCyc(c + 1);
            en = 1'b0;
            waitCyc(c + LAT + 3 * DIV + DIV / 2);
            checkOutput(tag("abortLineLow"), 32'(tx), 0);
            rst = 1'b1;
            waitCyc(cyc + 1);
            rst = 1'b0;
            checkOutput(tag("abortTx"), 32'(tx), 1);
            checkOutput(tag("abortReady"), 32'(ready), 1);
            checkOutput(tag("abortBusy"), 32'(busy), 0);
            sawDone = 1'b0;
            sawLow = 1'b0;
            for (int i = 0; i < 2 * DIV; i++) begin
                if (done) sawDone = 1'b1;
                if (!tx) sawLow = 1'b1;
                waitCyc(cyc + 1);
            end
            checkOutput(tag("abortNoDone"), 32'(sawDone), 0);
            checkOutput(tag("abortLineStaysHigh"), 32'(sawLow), 0);

`ifndef UART_TX_FIFO_EN
            @(negedge clk);
            c = cyc;
            en = 1'b1;
            txdata = d[NB-1:0];
            waitCyc(c + 1);
            en = 1'b0;
            checkFrame(c + 1, d, 1'b0, 1'b0);
`else
            // Burst of DEPTH+2 writes on consecutive cycles; occupancy model decides acceptance.
            occ = 0;
            idle = 1'b1;
            popCyc = 0;
            for (int k = 0; k < DEPTH + 2; k++) begin
                @(negedge clk);
                w = 9'h041 + 9'(k);
                en = 1'b1;
                txdata = w[NB-1:0];
                checkOutput(tag($sformatf("fifoReady%0d", k)), 32'(ready), 32'(occ < DEPTH));
                if (idle && occ > 0) begin
                    idle = 1'b0;
                    popCyc = cyc;
                    occ--;
                end
                if (occ + ((popCyc == cyc) ? 1 : 0) < DEPTH) begin
                    fq.push_back(w);
                    occ++;
                end
            end
            waitCyc(cyc + 1);
            en = 1'b0;
            c = popCyc + 1;
            for (int f = 0; f < fq.size(); f++) begin
                checkFrame(c, fq[f], 1'((fq.size() - 1 - f) < DEPTH), 1'(f < fq.size() - 1));
                c = cyc + 1;
            end
            checkOutput(tag("fifoAccepted"), 32'(fq.size()), 32'(DEPTH + 1));
`endif
            fin = 1'b1;
        endtask

        initial applyStimulus();
    end

    initial begin
        bit allDone;
        allDone = 1'b0;
        for (int t = 0; t < 150000 && !allDone; t++) begin
            @(posedge clk);
            allDone = gCfg[0].fin && gCfg[1].fin && gCfg[2].fin && gCfg[3].fin && gCfg[4].fin;
        end
        checkOutput("allConfigsFinished", 32'(allDone), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
